// File: rtl/vend_controller.sv
// ---------------------------------------------------------------------------
// vend_controller
//
// Coin-operated vending controller. Accepts 10/20/50 coins up to MAX_CREDIT,
// dispenses one of four priced items and pays change back as a sequence of
// 10-unit coins. A single FSM (IDLE, COLLECT, VEND, CHANGE) owns all state.
//
// Optional feature (macro VEND_TIMEOUT_EN):
//   When defined, COLLECT auto-refunds after TIMEOUT_CYCLES cycles without
//   coin_valid or sel_valid, pulsing timeout. When undefined, timeout is
//   constant 0 and COLLECT waits indefinitely.
//
// Parameters:
//   PRICE0..PRICE3  item prices (multiples of 10)
//   MAX_CREDIT      highest credit accepted (multiple of 10, <= 250)
//   TIMEOUT_CYCLES  COLLECT inactivity limit (VEND_TIMEOUT_EN only)
//
// Ports:
//   clk          rising-edge clock
//   reset        synchronous active-high reset
//   coin_valid   coin presented this cycle
//   coin         00=10, 01=20, 10=50, 11=invalid
//   sel_valid    product selection presented this cycle
//   sel          selected item 0..3
//   cancel       refund request
//   vend_ack     dispense completed
//   change_ack   one 10-unit coin ejected
//   credit       current credit
//   vend_req     dispense request (high in VEND)
//   vend_item    item being dispensed
//   change_req   payout request (high in CHANGE)
//   coin_reject  one-cycle pulse, coin returned
//   sel_reject   one-cycle pulse, selection refused
//   busy         high in VEND and CHANGE
//   timeout      one-cycle pulse on inactivity expiry
// ---------------------------------------------------------------------------
module vend_controller #(
    parameter int PRICE0         = 40,
    parameter int PRICE1         = 30,
    parameter int PRICE2         = 60,
    parameter int PRICE3         = 80,
    parameter int MAX_CREDIT     = 150,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       coin_valid,
    input  logic [1:0] coin,
    input  logic       sel_valid,
    input  logic [1:0] sel,
    input  logic       cancel,
    input  logic       vend_ack,
    input  logic       change_ack,
    output logic [7:0] credit,
    output logic       vend_req,
    output logic [1:0] vend_item,
    output logic       change_req,
    output logic       coin_reject,
    output logic       sel_reject,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_VEND    = 2'd2;
    localparam logic [1:0] ST_CHANGE  = 2'd3;

    logic [1:0] state;

    // Coin value decode; the invalid code maps to 0 and is flagged separately.
    logic [7:0] coin_val;
    logic       coin_ok;
    logic [8:0] coin_sum;
    logic [7:0] price;

    always_comb begin
        coin_val = 8'd0;
        coin_ok  = 1'b1;
        case (coin)
            2'b00:   coin_val = 8'd10;
            2'b01:   coin_val = 8'd20;
            2'b10:   coin_val = 8'd50;
            default: coin_ok  = 1'b0;
        endcase
    end

    // Nine bits so an overflowing sum is compared, not wrapped.
    assign coin_sum = {1'b0, credit} + {1'b0, coin_val};

    always_comb begin
        price = 8'(PRICE0);
        case (sel)
            2'd0:    price = 8'(PRICE0);
            2'd1:    price = 8'(PRICE1);
            2'd2:    price = 8'(PRICE2);
            default: price = 8'(PRICE3);
        endcase
    end

`ifdef VEND_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] IDLE_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] idle_cnt;
    logic          timeout_r;

    assign timeout = timeout_r;
`else
    assign timeout = 1'b0;
`endif

    // Level outputs decode straight from the state flops, so they remain
    // registered outputs without a second copy of the state.
    assign vend_req   = (state == ST_VEND);
    assign change_req = (state == ST_CHANGE);
    assign busy       = (state == ST_VEND) || (state == ST_CHANGE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            credit      <= '0;
            vend_item   <= '0;
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            idle_cnt    <= '0;
            timeout_r   <= 1'b0;
`endif
        end else begin
            coin_reject <= 1'b0;
            sel_reject  <= 1'b0;
`ifdef VEND_TIMEOUT_EN
            // Cleared every cycle unless COLLECT sees an idle cycle below.
            idle_cnt    <= '0;
            timeout_r   <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
                    if (coin_valid) begin
                        if (coin_ok && (coin_sum <= 9'(MAX_CREDIT)) ) begin
                            credit <= coin_val;
                            state  <= ST_COLLECT;
                        end else begin
                            coin_reject <= 1'b1;
                        end
                    end
                end

                ST_COLLECT: begin
                    // Priority: cancel > coin > sel.
                    if (cancel) begin
                        state <= ST_CHANGE;
                        if (coin_valid)
                            coin_reject <= 1'b1;
                    end else if (coin_valid) begin
                        if (coin_ok && (coin_sum <= 9'(MAX_CREDIT)))
                            credit <= coin_sum[7:0];
                        else
                            coin_reject <= 1'b1;
                    end else if (sel_valid) begin
                        if (credit >= price) begin
                            vend_item <= sel;
                            credit    <= credit - price;
                            state     <= ST_VEND;
                        end else begin
                            sel_reject <= 1'b1;
                        end
                    end
`ifdef VEND_TIMEOUT_EN
                    else if (idle_cnt == IDLE_LAST) begin
                        timeout_r <= 1'b1;
                        state     <= ST_CHANGE;
                    end else begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
`endif
                end

                ST_VEND: begin
                    if (coin_valid)
                        coin_reject <= 1'b1;
                    if (vend_ack)
                        state <= (credit != 8'd0) ? ST_CHANGE : ST_IDLE;
                end

                default: begin // ST_CHANGE
                    if (coin_valid)
                        coin_reject <= 1'b1;
                    if (credit == 8'd0) begin
                        state <= ST_IDLE;
                    end else if (change_ack) begin
                        credit <= credit - 8'd10;
                        if (credit == 8'd10)
                            state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_controller.sv
// ---------------------------------------------------------------------------
// tb_vend_controller
//
// Directed bench for vend_controller with hand-computed expectations.
// Inputs are driven 1 time unit after a rising edge; outputs are checked
// 1 time unit after the edge that sampled them.
// ---------------------------------------------------------------------------
module tb_vend_controller;

    logic       clk = 1'b0;
    logic       reset;
    logic       coin_valid;
    logic [1:0] coin;
    logic       sel_valid;
    logic [1:0] sel;
    logic       cancel;
    logic       vend_ack;
    logic       change_ack;
    logic [7:0] credit;
    logic       vend_req;
    logic [1:0] vend_item;
    logic       change_req;
    logic       coin_reject;
    logic       sel_reject;
    logic       busy;
    logic       timeout;

    int n_cmp = 0;
    int n_err = 0;

    vend_controller #(
        .PRICE0        (40),
        .PRICE1        (30),
        .PRICE2        (60),
        .PRICE3        (80),
        .MAX_CREDIT    (150),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .coin_valid (coin_valid),
        .coin       (coin),
        .sel_valid  (sel_valid),
        .sel        (sel),
        .cancel     (cancel),
        .vend_ack   (vend_ack),
        .change_ack (change_ack),
        .credit     (credit),
        .vend_req   (vend_req),
        .vend_item  (vend_item),
        .change_req (change_req),
        .coin_reject(coin_reject),
        .sel_reject (sel_reject),
        .busy       (busy),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Apply one cycle of inputs, then release them after the sampling edge.
    task automatic tick(input logic cv, input logic [1:0] c, input logic sv,
                        input logic [1:0] s, input logic can, input logic va,
                        input logic ca);
        coin_valid = cv;  coin = c;
        sel_valid  = sv;  sel  = s;
        cancel     = can;
        vend_ack   = va;  change_ack = ca;
        @(posedge clk);
        #1;
        coin_valid = 1'b0; coin = 2'b00;
        sel_valid  = 1'b0; sel  = 2'b00;
        cancel     = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
    endtask

    task automatic put_coin(input logic [1:0] c);
        tick(1'b1, c, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic pick(input logic [1:0] s);
        tick(1'b0, 2'd0, 1'b1, s, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_cycle();
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        idle_cycle();
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        coin_valid = 1'b0; coin = 2'b00;
        sel_valid  = 1'b0; sel  = 2'b00;
        cancel = 1'b0; vend_ack = 1'b0; change_ack = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;

        // Reset state
        chk("rst_credit", credit, 0);
        chk("rst_vreq", vend_req, 0);
        chk("rst_creq", change_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_item", vend_item, 0);
        chk("rst_crej", coin_reject, 0);
        chk("rst_srej", sel_reject, 0);
        chk("rst_tmo", timeout, 0);

        // Selection and cancel in IDLE are ignored
        tick(1'b0, 2'd0, 1'b1, 2'd1, 1'b1, 1'b0, 1'b0);
        chk("idle_sel_srej", sel_reject, 0);
        chk("idle_sel_creq", change_req, 0);

        // Coins 10,20,10 then item 0 (exact price)
        put_coin(2'b00); chk("a_c10", credit, 10);
        put_coin(2'b01); chk("a_c30", credit, 30);
        put_coin(2'b00); chk("a_c40", credit, 40);
        pick(2'd0);
        chk("a_vreq", vend_req, 1);
        chk("a_item", vend_item, 0);
        chk("a_credit", credit, 0);
        chk("a_busy", busy, 1);
        idle_cycle();
        chk("a_vreq_hold", vend_req, 1);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("a_ack_vreq", vend_req, 0);
        chk("a_ack_creq", change_req, 0);
        chk("a_ack_busy", busy, 0);

        // Coin 50, item 1, change of 20
        put_coin(2'b10); chk("b_c50", credit, 50);
        pick(2'd1);
        chk("b_vreq", vend_req, 1);
        chk("b_item", vend_item, 1);
        chk("b_credit", credit, 20);
        put_coin(2'b00);
        chk("b_vend_crej", coin_reject, 1);
        chk("b_vend_credit", credit, 20);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        chk("b_creq", change_req, 1);
        chk("b_vreq_off", vend_req, 0);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("b_chg1", credit, 10);
        chk("b_chg1_req", change_req, 1);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("b_chg2", credit, 0);
        chk("b_chg2_req", change_req, 0);
        chk("b_busy", busy, 0);

        // Coin 20, refused item 3, stray acks, cancel and refund
        put_coin(2'b01); chk("c_c20", credit, 20);
        pick(2'd3);
        chk("c_srej", sel_reject, 1);
        chk("c_credit", credit, 20);
        chk("c_vreq", vend_req, 0);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1);
        chk("c_srej_pulse", sel_reject, 0);
        chk("c_stray_ack", credit, 20);
        chk("c_stray_vreq", vend_req, 0);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("c_cancel_creq", change_req, 1);
        chk("c_cancel_credit", credit, 20);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("c_chg1", credit, 10);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("c_chg2", credit, 0);
        chk("c_idle", change_req, 0);

        // Credit ceiling, invalid coin, coin+sel same cycle
        put_coin(2'b10); put_coin(2'b10); put_coin(2'b10);
        chk("d_c150", credit, 150);
        chk("d_crej0", coin_reject, 0);
        put_coin(2'b00);
        chk("d_over_crej", coin_reject, 1);
        chk("d_over_credit", credit, 150);
        put_coin(2'b11);
        chk("d_bad_crej", coin_reject, 1);
        chk("d_bad_credit", credit, 150);
        tick(1'b1, 2'b00, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0);
        chk("d_cs_crej", coin_reject, 1);
        chk("d_cs_srej", sel_reject, 0);
        chk("d_cs_vreq", vend_req, 0);
        do_reset();
        chk("d_rst_credit", credit, 0);

        // Invalid coin in IDLE, then coin+cancel, then reset in CHANGE
        put_coin(2'b11);
        chk("e_idle_bad_crej", coin_reject, 1);
        chk("e_idle_bad_credit", credit, 0);
        put_coin(2'b01); chk("e_c20", credit, 20);
        tick(1'b1, 2'b01, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0);
        chk("e_cc_crej", coin_reject, 1);
        chk("e_cc_creq", change_req, 1);
        chk("e_cc_credit", credit, 20);
        do_reset();
        chk("e_rst_credit", credit, 0);
        chk("e_rst_creq", change_req, 0);
        chk("e_rst_busy", busy, 0);

        // Inactivity in COLLECT
        put_coin(2'b00); chk("f_c10", credit, 10);
`ifdef VEND_TIMEOUT_EN
        for (int i = 0; i < 15; i++) begin
            idle_cycle();
            chk("f_tmo_early", timeout, 0);
        end
        idle_cycle();
        chk("f_tmo_pulse", timeout, 1);
        chk("f_tmo_creq", change_req, 1);
        chk("f_tmo_credit", credit, 10);
        tick(1'b0, 2'd0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
        chk("f_tmo_once", timeout, 0);
        chk("f_refund", credit, 0);
        chk("f_idle", change_req, 0);
`else
        for (int i = 0; i < 16; i++) begin
            idle_cycle();
            chk("f_no_tmo", timeout, 0);
        end
        chk("f_wait_credit", credit, 10);
        chk("f_wait_creq", change_req, 0);
        chk("f_wait_vreq", vend_req, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
